// File: rtl/display_scan_controller_if.sv
// display_scan_controller_if: valid/ready load port carrying a packed BCD value
interface display_scan_controller_if #(parameter int N_DIG = 4);
    logic                 load_valid;
    logic                 load_ready;
    logic [4*N_DIG-1:0]   load_data;
    modport master (output load_valid, output load_data, input load_ready);
    modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/display_scan_controller.sv
// display_scan_controller: multiplexed seven-segment scan with tear-free buffered loads,
// anti-ghosting blank window and leading-zero suppression
module display_scan_controller #(
    parameter int N_DIG       = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        lz_blank,
    display_scan_controller_if.slave    load,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [N_DIG-1:0]            an,
    output logic                        frame_done
);
    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(N_DIG);
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [4*N_DIG-1:0]   active, pending;
    logic                 pend_full;
    logic                 last_cnt, boundary, xfer, sup;
    logic [3:0]           digit;
    logic [N_DIG-1:0]     upper_zero;
    logic [6:0]           seg_n;
    logic [N_DIG-1:0]     an_n;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign dp              = 1'b1;
    assign load.load_ready = !pend_full;
    assign xfer            = load.load_valid && !pend_full;
    assign last_cnt        = cnt == CW'(REFRESH_DIV - 1);
    assign boundary        = en && last_cnt && idx == IW'(N_DIG - 1);
    assign digit           = active[{idx, 2'b00} +: 4];

    // upper_zero[k]: digit k and every digit above it are zero
    always_comb begin
        upper_zero = '0;
        upper_zero[N_DIG-1] = active[4*N_DIG-1 -: 4] == 4'd0;
        for (int k = N_DIG - 2; k >= 0; k--)
            upper_zero[k] = upper_zero[k+1] && active[4*k +: 4] == 4'd0;
    end

    always_comb begin
        sup   = lz_blank && idx != '0 && upper_zero[idx];
        seg_n = (!en || cnt < CW'(BLANK_CYC) || sup) ? 7'h7F : decode(digit);
        an_n  = (en && cnt >= CW'(BLANK_CYC)) ? ~(N_DIG'(1) << idx) : '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            active     <= '0;
            pending    <= '0;
            pend_full  <= 1'b0;
            seg        <= 7'h7F;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            cnt        <= (!en || last_cnt) ? '0 : cnt + 1'b1;
            idx        <= !en ? '0 : !last_cnt ? idx : idx == IW'(N_DIG - 1) ? '0 : idx + 1'b1;
            // a transfer implies pend_full was clear, so it never collides with an apply
            if (xfer) begin
                pending   <= load.load_data;
                pend_full <= 1'b1;
            end else if (pend_full && (!en || boundary)) begin
                active    <= pending;
                pend_full <= 1'b0;
            end
            seg        <= seg_n;
            an         <= an_n;
            frame_done <= boundary;
        end
    end
endmodule
